// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle into a single broadcast register.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [3:0] cr0;
        logic       xer_so;
        logic       xer_ov;
        logic       xer_ca;
    } cond_exception_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned UNITS       = 4,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [UNITS-1:0]                     unit_valid,
    output logic [UNITS-1:0]                     unit_ready,
    input  logic [UNITS*RS_ID_WIDTH-1:0]         unit_rs_id,
    input  logic [UNITS*5-1:0]                   unit_result_reg_addr,
    input  logic [UNITS*32-1:0]                  unit_result,
    input  logic [UNITS*$bits(cond_exception_t)-1:0] unit_cr0_xer,
    output logic                                 cdb_valid,
    input  logic                                 cdb_ready,
    output logic [RS_ID_WIDTH-1:0]               cdb_rs_id,
    output logic [4:0]                           cdb_result_reg_addr,
    output logic [31:0]                          cdb_result,
    output cond_exception_t                      cdb_cr0_xer
);

    localparam int unsigned CxW = $bits(cond_exception_t);

    logic                   cdb_valid_q;
    logic [RS_ID_WIDTH-1:0] rs_id_q;
    logic [4:0]             reg_addr_q;
    logic [31:0]            result_q;
    cond_exception_t        cr0_xer_q;

    logic [UNITS-1:0]       gnt;
    logic                   reg_free;
    logic                   handshake;

    logic [RS_ID_WIDTH-1:0] sel_rs_id;
    logic [4:0]             sel_reg_addr;
    logic [31:0]            sel_result;
    cond_exception_t        sel_cr0_xer;

`ifdef CDB_ROUND_ROBIN_EN
    localparam int unsigned PtrW = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] gnt_idx;
    logic            found;
    int unsigned     idx;

    // Search starts one past the last granted unit so every requester is reached in turn.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= UNITS; k++) begin
            idx = (32'(ptr_q) + k) % UNITS;
            if (!found && unit_valid[PtrW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = PtrW'(idx);
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PtrW'(UNITS - 1);
        end else if (handshake) begin
            ptr_q <= gnt_idx;
        end
    end
`else
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < UNITS; i++) begin
            if (!found && unit_valid[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    assign reg_free   = !cdb_valid_q || cdb_ready;
    // Gating with rst keeps the ready path quiet for the whole reset window.
    assign unit_ready = gnt & {UNITS{reg_free & rst}};
    assign handshake  = |(unit_ready & unit_valid);

    always_comb begin
        sel_rs_id    = '0;
        sel_reg_addr = '0;
        sel_result   = '0;
        sel_cr0_xer  = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (unit_ready[i]) begin
                sel_rs_id    = unit_rs_id[i*RS_ID_WIDTH +: RS_ID_WIDTH];
                sel_reg_addr = unit_result_reg_addr[i*5 +: 5];
                sel_result   = unit_result[i*32 +: 32];
                sel_cr0_xer  = unit_cr0_xer[i*CxW +: CxW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            rs_id_q     <= '0;
            reg_addr_q  <= '0;
            result_q    <= '0;
            cr0_xer_q   <= '0;
        end else if (handshake) begin
            cdb_valid_q <= 1'b1;
            rs_id_q     <= sel_rs_id;
            reg_addr_q  <= sel_reg_addr;
            result_q    <= sel_result;
            cr0_xer_q   <= sel_cr0_xer;
        end else if (cdb_ready) begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign cdb_valid           = cdb_valid_q;
    assign cdb_rs_id           = rs_id_q;
    assign cdb_result_reg_addr = reg_addr_q;
    assign cdb_result          = result_q;
    assign cdb_cr0_xer         = cr0_xer_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow the build's arbitration mode.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned UNITS = 4;
    localparam int unsigned RSW   = 5;
    localparam int unsigned CW    = $bits(cond_exception_t);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [UNITS-1:0]       unit_valid;
    logic [UNITS-1:0]       unit_ready;
    logic                   cdb_ready;
    logic                   cdb_valid;
    logic [RSW-1:0]         cdb_rs_id;
    logic [4:0]             cdb_result_reg_addr;
    logic [31:0]            cdb_result;
    cond_exception_t        cdb_cr0_xer;

    logic [RSW-1:0] rs  [UNITS];
    logic [4:0]     ra  [UNITS];
    logic [31:0]    res [UNITS];
    logic [CW-1:0]  cx  [UNITS];

    logic [UNITS*RSW-1:0] unit_rs_id;
    logic [UNITS*5-1:0]   unit_result_reg_addr;
    logic [UNITS*32-1:0]  unit_result;
    logic [UNITS*CW-1:0]  unit_cr0_xer;

    assign unit_rs_id           = {rs[3], rs[2], rs[1], rs[0]};
    assign unit_result_reg_addr = {ra[3], ra[2], ra[1], ra[0]};
    assign unit_result          = {res[3], res[2], res[1], res[0]};
    assign unit_cr0_xer         = {cx[3], cx[2], cx[1], cx[0]};

    cdb_arbiter #(
        .UNITS       (UNITS),
        .RS_ID_WIDTH (RSW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .unit_valid           (unit_valid),
        .unit_ready           (unit_ready),
        .unit_rs_id           (unit_rs_id),
        .unit_result_reg_addr (unit_result_reg_addr),
        .unit_result          (unit_result),
        .unit_cr0_xer         (unit_cr0_xer),
        .cdb_valid            (cdb_valid),
        .cdb_ready            (cdb_ready),
        .cdb_rs_id            (cdb_rs_id),
        .cdb_result_reg_addr  (cdb_result_reg_addr),
        .cdb_result           (cdb_result),
        .cdb_cr0_xer          (cdb_cr0_xer)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected grant sequences for 1111 (eight cycles) and 1010 (four cycles).
`ifdef CDB_ROUND_ROBIN_EN
    int exp_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_d [4] = '{3, 1, 3, 1};
`else
    int exp_b [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int exp_d [4] = '{1, 1, 1, 1};
`endif

    initial begin
        for (int i = 0; i < UNITS; i++) begin
            rs[i]  = RSW'(17 + i);
            ra[i]  = 5'(3 + i);
            res[i] = 32'hA000_0000 + 32'(i);
            cx[i]  = CW'(7'h41 + 7'(i));
        end
        rst        = 1'b0;
        unit_valid = 4'b1111;
        cdb_ready  = 1'b1;

        // Reset state, with all units requesting.
        #1;
        check("rst_ready", 64'(unit_ready), 64'h0);
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_result", 64'(cdb_result), 64'h0);
        check("rst_rs_id", 64'(cdb_rs_id), 64'h0);
        tick();
        check("rst_edge_valid", 64'(cdb_valid), 64'h0);

        unit_valid = 4'b0000;
        rst        = 1'b1;
        #1;
        check("idle_ready", 64'(unit_ready), 64'h0);

        // Single request from unit 0, latency 1.
        res[0]     = 32'h0000_0007;
        unit_valid = 4'b0001;
        #1;
        check("a_ready", 64'(unit_ready), 64'h1);
        tick();
        unit_valid = 4'b0000;
        #1;
        check("a_valid", 64'(cdb_valid), 64'h1);
        check("a_result", 64'(cdb_result), 64'h7);
        check("a_rs_id", 64'(cdb_rs_id), 64'(rs[0]));
        check("a_reg_addr", 64'(cdb_result_reg_addr), 64'(ra[0]));
        check("a_cr0_xer", 64'(cdb_cr0_xer), 64'(cx[0]));
        tick();
        check("a_drain", 64'(cdb_valid), 64'h0);
        res[0] = 32'hA000_0000;

        // Async reset pulse restores the pointer before the all-request sweep.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            unit_valid = 4'b1111;
            #1;
            check($sformatf("b_grant%0d", k), 64'(unit_ready), 64'(4'b0001 << exp_b[k]));
            if (k > 0) begin
                check($sformatf("b_valid%0d", k), 64'(cdb_valid), 64'h1);
                check($sformatf("b_result%0d", k), 64'(cdb_result), 64'(res[exp_b[k-1]]));
            end
            tick();
        end
        unit_valid = 4'b0000;
        #1;
        check("b_last_result", 64'(cdb_result), 64'(res[exp_b[7]]));
        check("b_idle_ready", 64'(unit_ready), 64'h0);
        tick();
        check("b_drain", 64'(cdb_valid), 64'h0);

        // Backpressure: hold the broadcast while unit 1 waits.
        cdb_ready  = 1'b0;
        unit_valid = 4'b0001;
        #1;
        check("c_ready0", 64'(unit_ready), 64'h1);
        tick();
        unit_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("c_stall_ready%0d", k), 64'(unit_ready), 64'h0);
            check($sformatf("c_stall_valid%0d", k), 64'(cdb_valid), 64'h1);
            check($sformatf("c_stall_result%0d", k), 64'(cdb_result), 64'(res[0]));
            tick();
        end
        cdb_ready = 1'b1;
        #1;
        check("c_ready1", 64'(unit_ready), 64'h2);
        tick();
        unit_valid = 4'b0000;
        #1;
        check("c_valid", 64'(cdb_valid), 64'h1);
        check("c_result", 64'(cdb_result), 64'(res[1]));
        tick();

        // Units 1 and 3 both requesting.
        for (int k = 0; k < 4; k++) begin
            unit_valid = 4'b1010;
            #1;
            check($sformatf("d_grant%0d", k), 64'(unit_ready), 64'(4'b0001 << exp_d[k]));
            tick();
        end

        // Reset while a broadcast is held and unit 2 is pending.
        cdb_ready  = 1'b0;
        unit_valid = 4'b0100;
        #1;
        check("e_blocked", 64'(unit_ready), 64'h0);
        tick();
        check("e_held", 64'(cdb_valid), 64'h1);
        rst = 1'b0;
        #1;
        check("e_rst_valid", 64'(cdb_valid), 64'h0);
        check("e_rst_ready", 64'(unit_ready), 64'h0);
        check("e_rst_result", 64'(cdb_result), 64'h0);
        tick();
        rst = 1'b1;
        #1;
        check("e_first_grant", 64'(unit_ready), 64'h4);
        tick();
        unit_valid = 4'b0000;
        #1;
        check("e_valid", 64'(cdb_valid), 64'h1);
        check("e_result", 64'(cdb_result), 64'(res[2]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
